// File: rtl/dmem_arb2.sv
// Two-requester round-robin arbiter for one single-port SRAM, with a credit-controlled response FIFO per requester.
// Optional burst grant lock: define DMEM_ARB_BURST_LOCK_EN.
module dmem_arb2 #(
    parameter int AWIDTH     = 20,
    parameter int DWIDTH     = 64,
    parameter int RBUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req_valid,
    output logic              r0_req_ready,
    input  logic [AWIDTH-1:0] r0_req_addr,
    input  logic              r0_req_we,
    input  logic [DWIDTH-1:0] r0_req_wdata,
    input  logic              r0_req_last,
    output logic              r0_resp_valid,
    input  logic              r0_resp_ready,
    output logic [DWIDTH-1:0] r0_resp_data,
    input  logic              r1_req_valid,
    output logic              r1_req_ready,
    input  logic [AWIDTH-1:0] r1_req_addr,
    input  logic              r1_req_we,
    input  logic [DWIDTH-1:0] r1_req_wdata,
    input  logic              r1_req_last,
    output logic              r1_resp_valid,
    input  logic              r1_resp_ready,
    output logic [DWIDTH-1:0] r1_resp_data,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_din,
    input  logic [DWIDTH-1:0] mem_dout,
    output logic              mem_en,
    output logic              mem_we
);
    localparam int PW = $clog2(RBUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(RBUF_DEPTH);

    logic [1:0]        req_valid, req_we, resp_ready, elig, grant, push, pop, resp_valid;
    logic [AWIDTH-1:0] req_addr  [2];
    logic [DWIDTH-1:0] req_wdata [2];
    logic              rr_last, pend_valid, pend_id, win_id, fire;
    logic [CW-1:0]     count  [2];
    logic [PW-1:0]     wr_ptr [2];
    logic [PW-1:0]     rd_ptr [2];
    logic [DWIDTH-1:0] rbuf   [2][RBUF_DEPTH];

    assign req_valid    = {r1_req_valid, r0_req_valid};
    assign req_we       = {r1_req_we, r0_req_we};
    assign resp_ready   = {r1_resp_ready, r0_resp_ready};
    assign req_addr[0]  = r0_req_addr;
    assign req_addr[1]  = r1_req_addr;
    assign req_wdata[0] = r0_req_wdata;
    assign req_wdata[1] = r1_req_wdata;

    // A slot is reserved for a read still in flight, so credit never overcommits the FIFO.
    for (genvar g = 0; g < 2; g++) begin : g_req
        logic [CW:0] used;
        assign used          = {1'b0, count[g]} + (CW+1)'(pend_valid && pend_id == 1'(g));
        assign elig[g]       = req_valid[g] && (req_we[g] || used < DEPTH_V);
        assign push[g]       = pend_valid && pend_id == 1'(g);
        assign resp_valid[g] = count[g] != '0;
        assign pop[g]        = resp_valid[g] && resp_ready[g];
    end

`ifdef DMEM_ARB_BURST_LOCK_EN
    logic [1:0] req_last;
    logic       lock_active, lock_id;
    assign req_last = {r1_req_last, r0_req_last};

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_active <= 1'b0;
            lock_id     <= 1'b0;
        end else if (fire) begin
            lock_active <= !req_last[win_id];
            lock_id     <= win_id;
        end
    end
`else
    logic unused_last;
    assign unused_last = r0_req_last ^ r1_req_last;
`endif

    always_comb begin
        grant = 2'b00;
        if (elig == 2'b11) grant = rr_last ? 2'b01 : 2'b10;
        else               grant = elig;
`ifdef DMEM_ARB_BURST_LOCK_EN
        if (lock_active) grant = lock_id ? (elig & 2'b10) : (elig & 2'b01);
`endif
    end

    assign fire          = |grant;
    assign win_id        = grant[1];
    assign r0_req_ready  = grant[0];
    assign r1_req_ready  = grant[1];
    assign mem_en        = fire;
    assign mem_we        = fire && req_we[win_id];
    assign mem_addr      = req_addr[win_id];
    assign mem_din       = req_wdata[win_id];
    assign r0_resp_valid = resp_valid[0];
    assign r1_resp_valid = resp_valid[1];
    assign r0_resp_data  = rbuf[0][rd_ptr[0]];
    assign r1_resp_data  = rbuf[1][rd_ptr[1]];

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last    <= 1'b1;
            pend_valid <= 1'b0;
            pend_id    <= 1'b0;
            for (int n = 0; n < 2; n++) begin
                count[n]  <= '0;
                wr_ptr[n] <= '0;
                rd_ptr[n] <= '0;
            end
        end else begin
            if (fire) rr_last <= win_id;
            pend_valid <= fire && !req_we[win_id];
            if (fire && !req_we[win_id]) pend_id <= win_id;
            for (int n = 0; n < 2; n++) begin
                if (push[n]) wr_ptr[n] <= wr_ptr[n] + 1'b1;
                if (pop[n])  rd_ptr[n] <= rd_ptr[n] + 1'b1;
                if (push[n] && !pop[n])      count[n] <= count[n] + 1'b1;
                else if (!push[n] && pop[n]) count[n] <= count[n] - 1'b1;
            end
        end
    end

    // Read data lands one cycle after the fire that launched it.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++)
            if (push[n]) rbuf[n][wr_ptr[n]] <= mem_dout;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int n = 0; n < 2; n++) begin
                if (push[n] && count[n] == CW'(RBUF_DEPTH)) $error("dmem_arb2: push on full FIFO %0d", n);
                if (pop[n] && count[n] == '0) $error("dmem_arb2: pop on empty FIFO %0d", n);
            end
        end
    end
`endif
endmodule

// File: tb/tb_dmem_arb2.sv
// Directed self-checking bench for dmem_arb2 with a behavioural 1-cycle-latency SRAM.
module tb_dmem_arb2;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_req_valid = 0, r0_req_ready, r0_req_we = 0, r0_req_last = 1;
    logic [19:0] r0_req_addr = 0;
    logic [63:0] r0_req_wdata = 0, r0_resp_data;
    logic        r0_resp_valid, r0_resp_ready = 1;
    logic        r1_req_valid = 0, r1_req_ready, r1_req_we = 0, r1_req_last = 1;
    logic [19:0] r1_req_addr = 0;
    logic [63:0] r1_req_wdata = 0, r1_resp_data;
    logic        r1_resp_valid, r1_resp_ready = 1;
    logic [19:0] mem_addr;
    logic [63:0] mem_din, mem_dout;
    logic        mem_en, mem_we;
    logic [63:0] sram [256];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_arb2 dut (
        .clk(clk), .rst(rst),
        .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_req_addr(r0_req_addr),
        .r0_req_we(r0_req_we), .r0_req_wdata(r0_req_wdata), .r0_req_last(r0_req_last),
        .r0_resp_valid(r0_resp_valid), .r0_resp_ready(r0_resp_ready), .r0_resp_data(r0_resp_data),
        .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_req_addr(r1_req_addr),
        .r1_req_we(r1_req_we), .r1_req_wdata(r1_req_wdata), .r1_req_last(r1_req_last),
        .r1_resp_valid(r1_resp_valid), .r1_resp_ready(r1_resp_ready), .r1_resp_data(r1_resp_data),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_en(mem_en), .mem_we(mem_we)
    );

    initial begin
        for (int i = 0; i < 256; i++) sram[i] = 64'h1000 + 64'(i);
        mem_dout = '0;
    end

    always @(posedge clk) begin
        if (mem_en && mem_we) sram[mem_addr[7:0]] <= mem_din;
        if (mem_en && !mem_we) mem_dout <= sram[mem_addr[7:0]];
    end

    // Inputs change 1 time unit after the rising edge; checks happen at the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        r0_req_valid = 0; r1_req_valid = 0; r0_req_last = 1; r1_req_last = 1;
        r0_resp_ready = 1; r1_resp_ready = 1;
    endtask

    task automatic drain(input int n);
        idle();
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    task automatic test_reset();
        rst = 1; idle();
        next_cycle(); next_cycle();
        rst = 0;
        #4;
        n_checks++; if (r0_resp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_r0_resp_valid got %b want 0", r0_resp_valid); end
        n_checks++; if (r1_resp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_r1_resp_valid got %b want 0", r1_resp_valid); end
        n_checks++; if (mem_en !== 1'b0) begin n_errors++; $display("FAIL reset_mem_en got %b want 0", mem_en); end
        n_checks++; if ({r1_req_ready, r0_req_ready} !== 2'b00) begin n_errors++; $display("FAIL reset_req_ready got %b want 00", {r1_req_ready, r0_req_ready}); end
    endtask

    task automatic test_single_read();
        next_cycle();
        r0_req_valid = 1; r0_req_we = 1; r0_req_addr = 20'h10; r0_req_wdata = 64'hA5A5;
        #4;
        n_checks++; if ({mem_en, mem_we, r0_req_ready} !== 3'b111) begin n_errors++; $display("FAIL sr_write_fire got %b want 111", {mem_en, mem_we, r0_req_ready}); end
        n_checks++; if (mem_addr !== 20'h10 || mem_din !== 64'hA5A5) begin n_errors++; $display("FAIL sr_write_bus got %h/%h want 10/a5a5", mem_addr, mem_din); end
        next_cycle();
        r0_req_we = 0;
        #4;
        n_checks++; if ({mem_en, mem_we, r0_req_ready} !== 3'b101) begin n_errors++; $display("FAIL sr_read_fire got %b want 101", {mem_en, mem_we, r0_req_ready}); end
        next_cycle();
        r0_req_valid = 0;
        #4;
        n_checks++; if (r0_resp_valid !== 1'b0) begin n_errors++; $display("FAIL sr_resp_early got %b want 0", r0_resp_valid); end
        next_cycle();
        #4;
        n_checks++; if (r0_resp_valid !== 1'b1 || r0_resp_data !== 64'hA5A5) begin n_errors++; $display("FAIL sr_resp got %b/%h want 1/a5a5", r0_resp_valid, r0_resp_data); end
        next_cycle();
        #4;
        n_checks++; if (r0_resp_valid !== 1'b0) begin n_errors++; $display("FAIL sr_resp_popped got %b want 0", r0_resp_valid); end
    endtask

    task automatic test_contention();
        rst = 1; idle(); next_cycle(); rst = 0;
        r0_req_valid = 1; r0_req_we = 0; r0_req_addr = 20'h10;
        r1_req_valid = 1; r1_req_we = 0; r1_req_addr = 20'h11;
        for (int k = 0; k < 6; k++) begin
            #4;
            n_checks++; if ({r1_req_ready, r0_req_ready} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin n_errors++; $display("FAIL cont_grant cycle %0d got %b", k, {r1_req_ready, r0_req_ready}); end
            if (k >= 2 && k % 2 == 0) begin
                n_checks++; if (r0_resp_valid !== 1'b1 || r0_resp_data !== 64'hA5A5) begin n_errors++; $display("FAIL cont_r0_resp cycle %0d got %b/%h want 1/a5a5", k, r0_resp_valid, r0_resp_data); end
            end
            if (k >= 3 && k % 2 == 1) begin
                n_checks++; if (r1_resp_valid !== 1'b1 || r1_resp_data !== 64'h1011) begin n_errors++; $display("FAIL cont_r1_resp cycle %0d got %b/%h want 1/1011", k, r1_resp_valid, r1_resp_data); end
            end
            next_cycle();
        end
        drain(4);
    endtask

    task automatic test_back_pressure();
        logic [9:0] exp_r0 = 10'b1010000101;
        logic [9:0] exp_r1 = 10'b0101111010;
        int idx = 0;
        for (int c = 0; c < 10; c++) begin
            r0_req_valid = (idx < 4); r0_req_we = 0; r0_req_addr = 20'h30 + 20'(idx);
            r0_resp_ready = (c >= 6);
            r1_req_valid = 1; r1_req_we = 1; r1_req_addr = 20'h40 + 20'(c); r1_req_wdata = 64'(c);
            #4;
            n_checks++; if ({r1_req_ready, r0_req_ready} !== {exp_r1[9-c], exp_r0[9-c]}) begin n_errors++; $display("FAIL bp_grant cycle %0d got %b want %b", c, {r1_req_ready, r0_req_ready}, {exp_r1[9-c], exp_r0[9-c]}); end
            if (c == 5 || c == 6) begin
                n_checks++; if (r0_resp_valid !== 1'b1 || r0_resp_data !== 64'h1030) begin n_errors++; $display("FAIL bp_resp0 cycle %0d got %b/%h want 1/1030", c, r0_resp_valid, r0_resp_data); end
            end
            if (c == 7) begin
                n_checks++; if (r0_resp_valid !== 1'b1 || r0_resp_data !== 64'h1031) begin n_errors++; $display("FAIL bp_resp1 got %b/%h want 1/1031", r0_resp_valid, r0_resp_data); end
            end
            if (c == 8) begin
                n_checks++; if (r0_resp_valid !== 1'b0) begin n_errors++; $display("FAIL bp_empty got %b want 0", r0_resp_valid); end
            end
            if (c == 9) begin
                n_checks++; if (r0_resp_valid !== 1'b1 || r0_resp_data !== 64'h1032) begin n_errors++; $display("FAIL bp_resp2 got %b/%h want 1/1032", r0_resp_valid, r0_resp_data); end
            end
            if (r0_req_ready) idx++;
            next_cycle();
        end
        idle();
        next_cycle();
        #4;
        n_checks++; if (r0_resp_valid !== 1'b1 || r0_resp_data !== 64'h1033) begin n_errors++; $display("FAIL bp_resp3 got %b/%h want 1/1033", r0_resp_valid, r0_resp_data); end
        drain(3);
    endtask

    task automatic test_read_then_write();
        r0_req_valid = 1; r0_req_we = 1; r0_req_addr = 20'h20; r0_req_wdata = 64'h1;
        next_cycle();
        r0_req_we = 0;
        #4;
        n_checks++; if (r0_req_ready !== 1'b1) begin n_errors++; $display("FAIL rw_read_grant got %b want 1", r0_req_ready); end
        next_cycle();
        r0_req_valid = 0; r1_req_valid = 1; r1_req_we = 1; r1_req_addr = 20'h20; r1_req_wdata = 64'h2;
        #4;
        n_checks++; if (r1_req_ready !== 1'b1 || mem_we !== 1'b1) begin n_errors++; $display("FAIL rw_write_grant got %b%b want 11", r1_req_ready, mem_we); end
        next_cycle();
        r1_req_valid = 0;
        #4;
        n_checks++; if (r0_resp_valid !== 1'b1 || r0_resp_data !== 64'h1) begin n_errors++; $display("FAIL rw_old_data got %b/%h want 1/1", r0_resp_valid, r0_resp_data); end
        next_cycle();
        r0_req_valid = 1; r0_req_we = 0; r0_req_addr = 20'h20;
        next_cycle();
        r0_req_valid = 0;
        next_cycle();
        #4;
        n_checks++; if (r0_resp_valid !== 1'b1 || r0_resp_data !== 64'h2) begin n_errors++; $display("FAIL rw_new_data got %b/%h want 1/2", r0_resp_valid, r0_resp_data); end
        drain(2);
    endtask

    task automatic test_reset_midflight();
        r0_req_valid = 1; r0_req_we = 0; r0_req_addr = 20'h10;
        #4;
        n_checks++; if (r0_req_ready !== 1'b1) begin n_errors++; $display("FAIL rst_mid_fire got %b want 1", r0_req_ready); end
        next_cycle();
        r0_req_valid = 0; rst = 1;
        next_cycle();
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            #4;
            n_checks++; if ({r1_resp_valid, r0_resp_valid} !== 2'b00) begin n_errors++; $display("FAIL rst_mid_resp cycle %0d got %b want 00", k, {r1_resp_valid, r0_resp_valid}); end
            next_cycle();
        end
        r0_req_valid = 1; r0_req_we = 0; r0_req_addr = 20'h10;
        r1_req_valid = 1; r1_req_we = 0; r1_req_addr = 20'h11;
        #4;
        n_checks++; if ({r1_req_ready, r0_req_ready} !== 2'b01) begin n_errors++; $display("FAIL rst_mid_tie got %b want 01", {r1_req_ready, r0_req_ready}); end
        next_cycle();
        drain(4);
    endtask

    task automatic test_burst();
`ifdef DMEM_ARB_BURST_LOCK_EN
        logic [7:0] exp_r0 = 8'b11110000;
        logic [7:0] exp_r1 = 8'b00001111;
`else
        logic [7:0] exp_r0 = 8'b10101010;
        logic [7:0] exp_r1 = 8'b01010101;
`endif
        int beats = 0;
        rst = 1; idle(); next_cycle(); rst = 0;
        r1_req_valid = 1; r1_req_we = 1; r1_req_addr = 20'h60; r1_req_wdata = 64'h77;
        for (int c = 0; c < 8; c++) begin
            r0_req_valid = (beats < 4); r0_req_we = 1; r0_req_addr = 20'h50 + 20'(beats);
            r0_req_wdata = 64'(beats); r0_req_last = (beats == 3);
            #4;
            n_checks++; if ({r1_req_ready, r0_req_ready} !== {exp_r1[7-c], exp_r0[7-c]}) begin n_errors++; $display("FAIL burst_grant cycle %0d got %b want %b", c, {r1_req_ready, r0_req_ready}, {exp_r1[7-c], exp_r0[7-c]}); end
            if (r0_req_ready) beats++;
            next_cycle();
        end
        drain(2);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_back_pressure();
        test_read_then_write();
        test_reset_midflight();
        test_burst();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
